// File: rtl/snake_scan_feeder_if.sv
// snake_scan_feeder_if
//   Groups the feeder's frame control, SRAM read port and pixel stream.
//   master : the feeder (drives SRAM reads, the pixel stream and status).
//   slave  : the environment (drives start, SRAM read data and data_ready).
//   Signals:
//     start       frame start pulse
//     mem_rd_en   SRAM read strobe
//     mem_addr    SRAM read address (row*COL + col)
//     mem_rdata   SRAM read data, one cycle after mem_rd_en
//     data_out    zero-extended pixel (channel c in bits [(c+1)*8-1 -: 8])
//     data_valid  data_out holds a pixel
//     data_ready  consumer accepts on data_valid & data_ready
//     busy        frame in progress
//     done        one-cycle pulse after the last pixel is accepted
interface snake_scan_feeder_if #(
  parameter int ADDR_W  = 14,
  parameter int CH_IN   = 4,
  parameter int PEA_NUM = 32
);
  logic                 start;
  logic                 mem_rd_en;
  logic [ADDR_W-1:0]    mem_addr;
  logic [CH_IN*8-1:0]   mem_rdata;
  logic [PEA_NUM*8-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, mem_rdata, data_ready,
    output mem_rd_en, mem_addr, data_out, data_valid, busy, done
  );

  modport slave (
    output start, mem_rdata, data_ready,
    input  mem_rd_en, mem_addr, data_out, data_valid, busy, done
  );
endinterface

// File: rtl/snake_scan_feeder.sv
// snake_scan_feeder
//   Reads a row-major input feature map from SRAM (one pixel of CH_IN
//   channels per word) and streams it in PE-array order: rows 0 and 1
//   column-interleaved, then rows 2..ROW-1 boustrophedon (even rows
//   right-to-left, odd rows left-to-right). A 2-entry output FIFO plus an
//   in-flight flag lets the stream run at one pixel per cycle and absorb
//   downstream stalls without ever overrunning the FIFO.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  snake_scan_feeder_if.master (start, SRAM read port, pixel stream,
//          busy/done status)
module snake_scan_feeder #(
  parameter int ROW     = 128,
  parameter int COL     = 128,
  parameter int CH_IN   = 4,
  parameter int PEA_NUM = 32,
  parameter int ADDR_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  snake_scan_feeder_if.master   bus
);

  localparam int RW = $clog2(ROW + 1);
  localparam int CW = $clog2(COL + 1);
  localparam int PW = CH_IN * 8;
  localparam int OW = PEA_NUM * 8;

  localparam logic [RW-1:0]     ROW_LAST = RW'(ROW - 1);
  localparam logic [CW-1:0]     COL_LAST = CW'(COL - 1);
  localparam logic [ADDR_W-1:0] COL_A    = ADDR_W'(COL);

  typedef enum logic [1:0] {IDLE, PAIR, SNAKE, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] row, row_nxt;
  logic [CW-1:0] col, col_nxt;
  logic          done_c;

  logic [1:0]    cnt;
  logic          vld_p1;     // a read issued last cycle returns this cycle
  logic          wr_ptr, rd_ptr;
  logic [PW-1:0] fifo_q [2];

  logic          pop, issue, empty;
  logic [ADDR_W-1:0] rd_addr;

  assign pop   = (cnt != 2'd0) && bus.data_ready;
  assign empty = (cnt == 2'd0) && !vld_p1;

  // Credit rule: stored + in-flight pixels, less the one leaving this cycle,
  // must leave room for the new read.
  assign issue = ((state == PAIR) || (state == SNAKE)) &&
                 (({1'b0, cnt} + {2'b0, vld_p1}) < (3'd2 + {2'b0, pop}));

  assign rd_addr = ADDR_W'(row) * COL_A + ADDR_W'(col);

  // ---- p0: scan position / read issue ----
  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = PAIR;
          row_nxt   = '0;
          col_nxt   = '0;
        end
      end
      PAIR: begin
        if (issue) begin
          if (row == '0) begin
            row_nxt = RW'(1);
          end else begin
            row_nxt = '0;
            if (col == COL_LAST) begin
              if (ROW == 2) begin
                state_nxt = DRAIN;
              end else begin
                // col already sits at COL-1, where row 2 starts
                state_nxt = SNAKE;
                row_nxt   = RW'(2);
              end
            end else begin
              col_nxt = col + 1'b1;
            end
          end
        end
      end
      SNAKE: begin
        if (issue) begin
          if (row[0] ? (col == COL_LAST) : (col == '0)) begin
            if (row == ROW_LAST) state_nxt = DRAIN;
            else                 row_nxt   = row + 1'b1;
          end else if (row[0]) begin
            col_nxt = col + 1'b1;
          end else begin
            col_nxt = col - 1'b1;
          end
        end
      end
      DRAIN: begin
        if (empty) begin
          done_c = 1'b1;
          // a start coinciding with done opens the next frame directly
          if (bus.start) begin
            state_nxt = PAIR;
            row_nxt   = '0;
            col_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      col   <= col_nxt;
    end
  end

  // ---- p1: SRAM return into the output FIFO ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      cnt    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      vld_p1 <= issue;
      cnt    <= cnt + {1'b0, vld_p1} - {1'b0, pop};
      if (vld_p1) wr_ptr <= ~wr_ptr;
      if (pop)    rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p1) fifo_q[wr_ptr] <= bus.mem_rdata;
  end

  // ---- p2: pixel stream out ----
  assign bus.mem_rd_en  = issue;
  assign bus.mem_addr   = issue ? rd_addr : '0;
  assign bus.data_valid = (cnt != 2'd0);
  assign bus.data_out   = (cnt != 2'd0) ? OW'(fifo_q[rd_ptr]) : '0;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_c;

endmodule

// File: tb/tb_snake_scan_feeder.sv
module tb_snake_scan_feeder;

  logic clk;
  logic rst;

  snake_scan_feeder_if #(.ADDR_W(14), .CH_IN(4), .PEA_NUM(32)) ifa ();
  snake_scan_feeder_if #(.ADDR_W(14), .CH_IN(4), .PEA_NUM(32)) ifb ();

  snake_scan_feeder #(.ROW(4), .COL(3), .CH_IN(4), .PEA_NUM(32), .ADDR_W(14)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  snake_scan_feeder #(.ROW(2), .COL(1), .CH_IN(4), .PEA_NUM(32), .ADDR_W(14)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  always #5 clk = ~clk;

  logic [31:0] mem_a [0:15];
  logic [31:0] mem_b [0:1];

  // SRAM models: data one cycle after the read strobe
  always @(posedge clk) begin
    if (ifa.mem_rd_en) ifa.mem_rdata <= mem_a[ifa.mem_addr[3:0]];
    if (ifb.mem_rd_en) ifb.mem_rdata <= mem_b[ifb.mem_addr[0]];
  end

  int n_total = 0;
  int n_pass  = 0;
  int exp_q[$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs == exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference scan order: interleave rows 0/1 by column, then snake the rest
  task automatic build_order(input int rows, input int cols);
    exp_q.delete();
    for (int c = 0; c < cols; c++) begin
      exp_q.push_back(c);
      exp_q.push_back(cols + c);
    end
    for (int r = 2; r < rows; r++) begin
      if (r % 2 == 0) for (int c = cols - 1; c >= 0; c--) exp_q.push_back(r * cols + c);
      else            for (int c = 0; c < cols; c++)      exp_q.push_back(r * cols + c);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rd_en"}, 256'(ifa.mem_rd_en), 256'(0));
    chk({tag, "_addr"},  256'(ifa.mem_addr),  256'(0));
    chk({tag, "_data"},  ifa.data_out,        256'(0));
    chk({tag, "_valid"}, 256'(ifa.data_valid), 256'(0));
    chk({tag, "_busy"},  256'(ifa.busy),      256'(0));
    chk({tag, "_done"},  256'(ifa.done),      256'(0));
  endtask

  // One 4x3 frame. rnd: random words and random ready; rst_at: reset at that
  // accepted pixel (0 = never); restart_at: cycle of an extra start pulse.
  task automatic frame_a(input bit rnd, input int rst_at, input int restart_at);
    int n_iss = 0, n_acc = 0, n_done = 0, outst = 0;
    int first_rd = -1, first_vld = -1, last_acc = -1;
    bit prev_stall = 0, stop = 0;
    logic [255:0] prev_data = '0;
    for (int i = 0; i < 16; i++) mem_a[i] = rnd ? $urandom : 32'(i);
    build_order(4, 3);
    for (int cyc = 0; cyc < 200 && !stop; cyc++) begin
      @(negedge clk);
      ifa.start      = (cyc == 0 || cyc == restart_at);
      ifa.data_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (cyc == 0) chk("idle_busy", 256'(ifa.busy), 256'(0));
      if (prev_stall) begin
        chk("stall_valid", 256'(ifa.data_valid), 256'(1));
        chk("stall_data", ifa.data_out, prev_data);
      end
      chk("data_hi_zero", 256'(ifa.data_out[255:32]), 256'(0));
      if (ifa.mem_rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        if (n_iss < exp_q.size()) chk("addr", 256'(ifa.mem_addr), 256'(exp_q[n_iss]));
        else chk_i("extra_read", n_iss, exp_q.size() - 1);
        n_iss++;
        outst++;
      end
      if (ifa.data_valid && first_vld < 0) first_vld = cyc;
      if (ifa.data_valid && ifa.data_ready) begin
        if (n_acc < exp_q.size()) chk("pixel", ifa.data_out, 256'(mem_a[exp_q[n_acc]]));
        else chk_i("extra_pixel", n_acc, exp_q.size() - 1);
        n_acc++;
        outst--;
        last_acc = cyc;
        if (n_acc == rst_at) begin
          rst = 1'b1;
          #1;
          chk_idle_outputs("mid_reset");
          @(negedge clk);
          rst = 1'b0;
          ifa.start = 1'b0;
          ifa.data_ready = 1'b0;
          return;
        end
      end
      chk_i("outstanding_le2", int'(outst <= 2), 1);
      if (ifa.done) begin
        n_done++;
        chk_i("done_timing", cyc, last_acc + 1);
      end
      prev_stall = ifa.data_valid && !ifa.data_ready;
      prev_data  = ifa.data_out;
      if (n_done > 0 && cyc > last_acc + 3) stop = 1;
    end
    ifa.start = 1'b0;
    chk_i("first_rd_cycle", first_rd, 1);
    chk_i("first_vld_cycle", first_vld, 3);
    chk_i("reads_issued", n_iss, 12);
    chk_i("pixels_accepted", n_acc, 12);
    chk_i("done_pulses", n_done, 1);
    chk("busy_after", 256'(ifa.busy), 256'(0));
  endtask

  // One 2x1 frame with data_ready held high
  task automatic frame_b();
    int n_iss = 0, n_acc = 0, n_done = 0, last_acc = -1;
    mem_b[0] = $urandom;
    mem_b[1] = $urandom;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      ifb.start      = (cyc == 0);
      ifb.data_ready = 1'b1;
      #1;
      if (ifb.mem_rd_en) begin
        if (n_iss < 2) chk("b_addr", 256'(ifb.mem_addr), 256'(n_iss));
        else chk_i("b_extra_read", n_iss, 1);
        n_iss++;
      end
      if (ifb.data_valid && ifb.data_ready) begin
        if (n_acc < 2) chk("b_pixel", ifb.data_out, 256'(mem_b[n_acc]));
        else chk_i("b_extra_pixel", n_acc, 1);
        n_acc++;
        last_acc = cyc;
      end
      if (ifb.done) begin
        n_done++;
        chk_i("b_done_timing", cyc, last_acc + 1);
      end
    end
    ifb.start = 1'b0;
    chk_i("b_reads", n_iss, 2);
    chk_i("b_pixels", n_acc, 2);
    chk_i("b_done_pulses", n_done, 1);
    chk("b_busy_after", 256'(ifb.busy), 256'(0));
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    ifa.start = 1'b0;
    ifa.data_ready = 1'b0;
    ifb.start = 1'b0;
    ifb.data_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    frame_a(1'b0, 0, -1);   // ready held high, word = address
    frame_a(1'b1, 0, -1);   // random stalls, random words
    frame_a(1'b1, 0, 6);    // extra start while busy
    frame_a(1'b0, 5, -1);   // reset at the 5th accepted pixel
    frame_a(1'b0, 0, -1);   // replay after reset
    frame_b();              // 2x1 frame, no snake rows
    frame_a(1'b1, 0, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
